nco_sweep_ctrl: RTL
===================

// Module: nco_sweep_ctrl
// PURPOSE
//  Frequency-sweep sequencer for the phase-accumulator NCO.
//  - Accepts one sweep descriptor per valid/ready handshake: start, step, stop, dwell, mode.
//  - Drives a runtime frequency control word (FCW) to the NCO increment input.
//  - Holds each FCW value for a programmed dwell, then steps it.
//  - Repeats or terminates at the stop word, enabling chirp and stepped-tone generation.
// PARAMETERS
//  ACC_W    32  width of FCW / NCO phase accumulator increment
//  DWELL_W  16  width of dwell counter
// PORTS
//  clk            in   1        system clock; all logic on posedge
//  reset          in   1        synchronous, active-high reset
//  cfg_valid      in   1        descriptor valid
//  cfg_ready      out  1        descriptor accepted when cfg_valid & cfg_ready
//  cfg_start_fcw  in   ACC_W    first FCW of sweep
//  cfg_step       in   ACC_W    unsigned FCW increment per step
//  cfg_stop_fcw   in   ACC_W    last permitted FCW (inclusive)
//  cfg_dwell      in   DWELL_W  cycles per FCW minus 1
//  cfg_repeat     in   1        0 = single sweep, 1 = wrap to start at end
//  abort          in   1        terminate sweep immediately
//  fcw_out        out  ACC_W    FCW to NCO
//  fcw_valid      out  1        fcw_out is being actively swept
//  busy           out  1        sweep in progress
//  done           out  1        one-cycle pulse on normal sweep completion
// BEHAVIOUR
//  Reset (sync, active-high; dominates all inputs):
//   - state=IDLE
//   - fcw_out=0, fcw_valid=0, busy=0, done=0, cfg_ready=1
//   - Reset mid-sweep has the same effect; no done pulse.
//  States IDLE, SWEEP:
//   - IDLE:
//     - cfg_ready = ~abort.
//     - On accept at edge N: latch descriptor; after edge N, fcw_out=start,
//       fcw_valid=1, busy=1, cfg_ready=0, dwell_cnt=cfg_dwell, state=SWEEP.
//   - SWEEP:
//     - cfg_valid is ignored (not accepted, not stored).
//     - dwell_cnt!=0 -> decrement; fcw_out holds.
//     - dwell_cnt==0 -> nxt = {1'b0,fcw_out} + {1'b0,step}, computed ACC_W+1 bits wide.
//     - end = nxt[ACC_W] | (nxt[ACC_W-1:0] > stop). Compare is unsigned; never wrap silently.
//       - ~end: fcw_out=nxt, dwell_cnt reload.
//       - end & repeat: fcw_out=start, dwell_cnt reload; no done pulse.
//       - end & ~repeat: state=IDLE, done=1 for one cycle, fcw_valid=0, busy=0,
//         cfg_ready=1 in that same cycle; fcw_out holds last value.
//  Dwell and step boundaries:
//   - Each FCW is held for exactly cfg_dwell+1 cycles; dwell=0 means a new FCW every cycle.
//   - step=0: end is never reached while start<=stop; sweep runs until abort.
//   - start>stop: start is emitted for one dwell, then the end rule applies
//     (done, or reload in repeat mode).
//  abort:
//   - In SWEEP: next state=IDLE, fcw_out=0, fcw_valid=0, busy=0, no done pulse.
//   - abort wins over simultaneous dwell expiry.
//   - abort & cfg_valid in IDLE: no accept.
//  The descriptor is latched at accept; later changes on cfg_* have no effect on a running sweep.
// STRUCTURE
//  Shared package nco_pkg:
//   - ACC_W default
//   - state enum {IDLE, SWEEP}
//   - sweep descriptor struct
//  One sub-module, nco_fcw_step:
//   - combinational (ACC_W+1)-bit add plus unsigned compare
//   - outputs nxt_fcw and end flag
//  Top-level: FSM, descriptor regs, dwell counter.
// TESTING
//  1. start=0x1000_0000 step=0x1000_0000 stop=0x4000_0000 dwell=2 single
//     -> fcw 0x1,0x2,0x3,0x4 (e28), 3 cycles each; done pulse 12 cycles after accept.
//  2. Same descriptor, repeat=1 -> after 0x4000_0000 returns to 0x1000_0000; no done;
//     abort -> fcw_out=0, busy=0 next cycle.
//  3. start=0xF000_0000 step=0x2000_0000 stop=0xFFFF_FFFF dwell=0
//     -> one cycle of 0xF000_0000 then done (carry end).
//  4. cfg_valid held high during SWEEP with a different descriptor
//     -> cfg_ready=0, sweep unchanged; accepted on the done cycle.
//  5. reset asserted mid-dwell -> all outputs reset values next cycle, no done;
//     abort + cfg_valid together in IDLE -> no accept.
//  6. step=0 dwell=0 -> fcw_out constant at start, busy stays 1 for 1000 cycles until abort.

Source files
------------

// File: rtl/nco_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nco_pkg
//  Description : Shared types and constants for the NCO frequency-sweep
//                sequencer (default widths, FSM state, sweep descriptor).
//  Revision    : 1.0  initial release
// ============================================================================
package nco_pkg;

    // Default width of the FCW / phase-accumulator increment
    localparam int c_ACC_W   = 32;
    // Default width of the per-FCW dwell counter
    localparam int c_DWELL_W = 16;

    // Sequencer state
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

    // One sweep descriptor as presented on the configuration interface
    typedef struct packed {
        logic [c_ACC_W-1:0]   start_fcw;
        logic [c_ACC_W-1:0]   step;
        logic [c_ACC_W-1:0]   stop_fcw;
        logic [c_DWELL_W-1:0] dwell;
        logic                 repeat_en;
    } sweep_desc_t;

endpackage : nco_pkg
`default_nettype wire

// File: rtl/nco_fcw_step.sv
`default_nettype none
// ============================================================================
//  Module      : nco_fcw_step
//  Description : Next-FCW calculator. Adds the step with one guard bit so a
//                carry out of the accumulator width is seen as end-of-sweep
//                instead of wrapping, and flags when the result passes stop.
//  Revision    : 1.0  initial release
// ============================================================================
module nco_fcw_step #(
    parameter int ACC_W = 32
) (
    input  logic [ACC_W-1:0] fcw,
    input  logic [ACC_W-1:0] step,
    input  logic [ACC_W-1:0] stop_fcw,
    output logic [ACC_W-1:0] nxt_fcw,
    output logic             end_sweep
);

    logic [ACC_W:0] w_sum;

    // Guarded add; the top bit is the carry out
    assign w_sum     = {1'b0, fcw} + {1'b0, step};
    assign nxt_fcw   = w_sum[ACC_W-1:0];
    // Unsigned compare; a carry always terminates the sweep
    assign end_sweep = w_sum[ACC_W] | (w_sum[ACC_W-1:0] > stop_fcw);

endmodule : nco_fcw_step
`default_nettype wire

// File: rtl/nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nco_sweep_ctrl
//  Description : Frequency-sweep sequencer for the phase-accumulator NCO.
//                Accepts a sweep descriptor, drives the FCW, holds each value
//                for dwell+1 cycles, steps it and repeats or finishes at stop.
//  Revision    : 1.0  initial release
// ============================================================================
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int ACC_W   = c_ACC_W,
    parameter int DWELL_W = c_DWELL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [ACC_W-1:0]   cfg_start_fcw,
    input  logic [ACC_W-1:0]   cfg_step,
    input  logic [ACC_W-1:0]   cfg_stop_fcw,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_repeat,
    input  logic               abort,
    output logic [ACC_W-1:0]   fcw_out,
    output logic               fcw_valid,
    output logic               busy,
    output logic               done
);

    sweep_state_t       r_state;
    logic [ACC_W-1:0]   r_start_fcw;
    logic [ACC_W-1:0]   r_step;
    logic [ACC_W-1:0]   r_stop_fcw;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_repeat;
    logic [DWELL_W-1:0] r_dwell_cnt;

    logic [ACC_W-1:0]   w_nxt_fcw;
    logic               w_end;
    logic               w_accept;

    // Next-FCW arithmetic works from the latched descriptor only
    nco_fcw_step #(
        .ACC_W (ACC_W)
    ) u_fcw_step (
        .fcw       (fcw_out),
        .step      (r_step),
        .stop_fcw  (r_stop_fcw),
        .nxt_fcw   (w_nxt_fcw),
        .end_sweep (w_end)
    );

    // A descriptor is only taken in IDLE, and never alongside abort
    assign cfg_ready = (r_state == IDLE) && !abort;
    assign w_accept  = cfg_valid && cfg_ready;

    // Sweep FSM, descriptor latch and dwell counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_start_fcw <= '0;
            r_step      <= '0;
            r_stop_fcw  <= '0;
            r_dwell     <= '0;
            r_repeat    <= 1'b0;
            r_dwell_cnt <= '0;
            fcw_out     <= '0;
            fcw_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_start_fcw <= cfg_start_fcw;
                        r_step      <= cfg_step;
                        r_stop_fcw  <= cfg_stop_fcw;
                        r_dwell     <= cfg_dwell;
                        r_repeat    <= cfg_repeat;
                        r_dwell_cnt <= cfg_dwell;
                        fcw_out     <= cfg_start_fcw;
                        fcw_valid   <= 1'b1;
                        busy        <= 1'b1;
                        r_state     <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        // Abort beats a coinciding dwell expiry
                        fcw_out   <= '0;
                        fcw_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end else if (r_dwell_cnt != '0) begin
                        r_dwell_cnt <= r_dwell_cnt - {{(DWELL_W-1){1'b0}}, 1'b1};
                    end else if (!w_end) begin
                        fcw_out     <= w_nxt_fcw;
                        r_dwell_cnt <= r_dwell;
                    end else if (r_repeat) begin
                        fcw_out     <= r_start_fcw;
                        r_dwell_cnt <= r_dwell;
                    end else begin
                        // Normal completion: last FCW stays on the bus
                        done      <= 1'b1;
                        fcw_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : nco_sweep_ctrl
`default_nettype wire
